reg_bus_rr_arbiter: RTL
=======================

Name: reg_bus_rr_arbiter

Overview:
- Shares the single peripheral register bus (SoC ctrl, boot ROM, fast-intr ctrl, UART window) between NumReq register-bus requesters.
- Typical requesters: the CPU path through the AXI-to-reg bridge and a debug or DMA port.
- Arbitration is round-robin with a registered grant; one transaction is in flight at a time.
- An optional watchdog terminates transactions the downstream slave never acknowledges.
- Sits between the requester-side reg bridges and the reg demux that decodes the peripheral map.

Parameters:
- NumReq, 2, number of requesters (≥1).
- TimeoutCycles, 256, cycles in BUSY without rsp_i.ready before forced error (≥2; used only with REG_ARB_TIMEOUT_EN).
- IdxWidth, (NumReq>1 ? $clog2(NumReq) : 1), width of index outputs.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; synchronous, active-high.
- req_i  input  reg_req_t[NumReq]  requester requests (addr, write, wdata, wstrb, valid).
- rsp_o  output  reg_rsp_t[NumReq]  requester responses (rdata, error, ready).
- req_o  output  reg_req_t  request to the peripheral reg bus.
- rsp_i  input  reg_rsp_t  response from the peripheral reg bus.
- gnt_idx_o  output  IdxWidth  index of the current owner; valid while busy_o=1.
- busy_o  output  1  transaction in flight.
- timeout_o  output  1  one-cycle pulse when the watchdog fires.
- timeout_idx_o  output  IdxWidth  requester that timed out; holds its value until the next timeout.

Behaviour:
- Reset is synchronous: on a clk_i edge with rst_i=1:
  - state=IDLE, rr_ptr=0, owner=0, timer=0.
  - busy_o=0, timeout_o=0, timeout_idx_o=0, gnt_idx_o=0.
  - req_o='0, all rsp_o='0.
- Reset mid-transaction: the downstream valid drops on the next cycle and no response is delivered to the owner. Requesters must also be reset.
- State machine: IDLE, BUSY.
- IDLE:
  - req_o.valid=0; all rsp_o.ready=0.
  - If any req_i[k].valid=1, pick the first valid index scanning rr_ptr, rr_ptr+1, … with wrap modulo NumReq.
  - Next cycle: owner=winner, state=BUSY, timer=0.
- BUSY:
  - req_o = req_i[owner] (combinational pass-through).
  - rsp_o[owner] = rsp_i; every other rsp_o = '0.
  - On rsp_i.ready=1, the transaction completes that cycle. Next cycle: state=IDLE, rr_ptr=(owner+1) mod NumReq.
- Latency:
  - Minimum 2 cycles from req_i.valid rising to rsp_o.ready: 1 grant cycle plus a zero-wait slave.
  - One IDLE bubble cycle separates back-to-back grants.
- Requester protocol: req_i[k] must hold valid and stable until its ready is seen. A valid that drops while owner is a protocol violation; the arbiter still waits for ready or timeout.
- Non-owners see ready=0 and must keep waiting. There is no starvation: the wait is at most NumReq-1 other transactions.
- Simultaneous events:
  - Several valids in the same IDLE cycle: the round-robin order decides.
  - rsp_i.ready and timer expiry in the same cycle: ready wins and there is no timeout.
- NumReq=1: the pointer is constant 0; behaviour is otherwise identical.

Optional Feature:
- Macro: REG_ARB_TIMEOUT_EN.
- Defined:
  - timer increments every BUSY cycle with rsp_i.ready=0.
  - When timer==TimeoutCycles-1 and ready=0:
    - rsp_o[owner] = {rdata=32'hDEAD_BEEF, error=1, ready=1}.
    - req_o.valid=0 that cycle.
    - timeout_o=1 for one cycle; timeout_idx_o=owner.
    - Next state=IDLE with the normal rr_ptr update.
  - timer width is $clog2(TimeoutCycles).
- Undefined:
  - No timer logic is present.
  - timeout_o=0 and timeout_idx_o=0 constantly.
  - BUSY waits for rsp_i.ready indefinitely.

Decomposition:
- Shared package core_v_mcu_pkg:
  - New constants RegArbNumReq and RegArbTimeoutCycles.
  - A new RegArbTimeoutRdata constant (32'hDEAD_BEEF).
  - Reuse the package's existing reg_req_t and reg_rsp_t.
- Sub-module reg_arb_rr_pick (combinational):
  - Inputs: valid vector and rr_ptr.
  - Outputs: winner index and any_valid.
  - Rotate, then find-first-one.
- The arbiter holds the FSM, the registered owner/pointer, muxing, and the timer.

Test Plan:
1. Single requester 0 writes addr 0x1000_3000, wdata 0x55, slave ready in its first BUSY cycle → rsp_o[0].ready asserted 2 cycles after valid; req_o.addr=0x1000_3000; rr_ptr becomes 1.
2. Both valid in the same cycle from reset → req 0 is granted first, then req 1 after one IDLE bubble. Repeat 4 times → grant order 0,1,0,1; busy_o low exactly one cycle between grants.
3. Slave ready held low 5 cycles, requester 1 read returning rdata 0xCAFE_F00D → rsp_o[1] rdata=0xCAFE_F00D, ready on cycle 6 of BUSY; rsp_o[0].ready=0 throughout.
4. With REG_ARB_TIMEOUT_EN and TimeoutCycles=8, slave never ready, owner=1 → on the 8th BUSY cycle rsp_o[1]={0xDEAD_BEEF, error=1, ready=1}; timeout_o pulses once; timeout_idx_o=1. Without the macro → busy_o stays 1 and timeout_o stays 0.
5. Timeout boundary: ready arrives exactly on cycle TimeoutCycles → normal completion, error=0, timeout_o=0.
6. rst_i asserted in the 3rd BUSY cycle → the next cycle shows req_o.valid=0, busy_o=0, all rsp_o.ready=0; after release, req 0 wins first.

Source files
------------

// File: rtl/core_v_mcu_pkg.sv
// core_v_mcu_pkg: shared register-bus types and arbiter constants
package core_v_mcu_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

    localparam int          RegArbNumReq        = 2;
    localparam int          RegArbTimeoutCycles = 256;
    localparam logic [31:0] RegArbTimeoutRdata  = 32'hDEAD_BEEF;

    typedef enum logic {ArbIdle, ArbBusy} reg_arb_state_e;

endpackage

// File: rtl/reg_arb_rr_pick.sv
// reg_arb_rr_pick: rotate valid vector by rr pointer, then find-first-one
module reg_arb_rr_pick #(
    parameter int NumReq   = 2,
    parameter int IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0]   valid_i,
    input  logic [IdxWidth-1:0] ptr_i,
    output logic [IdxWidth-1:0] idx_o,
    output logic                any_o
);

    localparam logic [IdxWidth:0] NumReqW = (IdxWidth+1)'(NumReq);

    logic [2*NumReq-1:0] w_dbl;
    logic [NumReq-1:0]   w_rot;
    logic [IdxWidth-1:0] w_off;
    logic [IdxWidth:0]   w_sum;

    assign w_dbl = {valid_i, valid_i} >> ptr_i;
    assign w_rot = w_dbl[NumReq-1:0];

    // lowest set bit of the rotated vector is the offset from the pointer
    always_comb begin
        w_off = '0;
        for (int i = NumReq - 1; i >= 0; i--)
            if (w_rot[i]) w_off = IdxWidth'(i);
    end

    assign w_sum = {1'b0, ptr_i} + {1'b0, w_off};
    assign idx_o = (w_sum >= NumReqW) ? IdxWidth'(w_sum - NumReqW) : IdxWidth'(w_sum);
    assign any_o = |valid_i;

endmodule

// File: rtl/reg_bus_rr_arbiter.sv
// reg_bus_rr_arbiter: round-robin register-bus arbiter, one transaction in flight; watchdog under REG_ARB_TIMEOUT_EN
module reg_bus_rr_arbiter
    import core_v_mcu_pkg::*;
#(
    parameter int NumReq        = RegArbNumReq,
    parameter int TimeoutCycles = RegArbTimeoutCycles,
    parameter int IdxWidth      = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  reg_req_t            req_i [NumReq],
    output reg_rsp_t            rsp_o [NumReq],
    output reg_req_t            req_o,
    input  reg_rsp_t            rsp_i,
    output logic [IdxWidth-1:0] gnt_idx_o,
    output logic                busy_o,
    output logic                timeout_o,
    output logic [IdxWidth-1:0] timeout_idx_o
);

    if (TimeoutCycles < 2) begin : g_bad_timeout
        $error("TimeoutCycles must be at least 2");
    end

    reg_arb_state_e      r_state, w_state_nxt;
    logic [IdxWidth-1:0] r_ptr, r_owner, w_win, w_ptr_nxt;
    logic [NumReq-1:0]   w_valid;
    logic                w_any, w_fire, w_done;

    // gather the valid bits of all requesters
    always_comb begin
        w_valid = '0;
        for (int k = 0; k < NumReq; k++) w_valid[k] = req_i[k].valid;
    end

    reg_arb_rr_pick #(.NumReq(NumReq), .IdxWidth(IdxWidth)) u_pick (
        .valid_i (w_valid),
        .ptr_i   (r_ptr),
        .idx_o   (w_win),
        .any_o   (w_any)
    );

`ifdef REG_ARB_TIMEOUT_EN
    localparam int TmrW = $clog2(TimeoutCycles);

    logic [TmrW-1:0]     r_timer;
    logic [IdxWidth-1:0] r_tidx;

    assign w_fire = busy_o && !rsp_i.ready && (r_timer == TmrW'(TimeoutCycles - 1));

    // count stalled BUSY cycles; cleared while idle so each grant starts at 0
    always_ff @(posedge clk_i)
        if (rst_i || !busy_o) r_timer <= '0;
        else if (!rsp_i.ready) r_timer <= r_timer + 1'b1;

    // remember which requester was last cut off by the watchdog
    always_ff @(posedge clk_i)
        if (rst_i) r_tidx <= '0;
        else if (w_fire) r_tidx <= r_owner;

    assign timeout_o     = w_fire;
    assign timeout_idx_o = w_fire ? r_owner : r_tidx;
`else
    assign w_fire        = 1'b0;
    assign timeout_o     = 1'b0;
    assign timeout_idx_o = '0;
`endif

    assign busy_o      = (r_state == ArbBusy);
    assign gnt_idx_o   = r_owner;
    assign w_done      = busy_o && (rsp_i.ready || w_fire);
    assign w_ptr_nxt   = (r_owner == IdxWidth'(NumReq - 1)) ? '0 : r_owner + 1'b1;
    assign w_state_nxt = busy_o ? (w_done ? ArbIdle : ArbBusy) : (w_any ? ArbBusy : ArbIdle);

    // state, owner latched at grant, pointer advanced past the owner on completion
    always_ff @(posedge clk_i)
        if (rst_i) begin
            r_state <= ArbIdle;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!busy_o && w_any) r_owner <= w_win;
            if (w_done) r_ptr <= w_ptr_nxt;
        end

    // route the owner's request downstream and the slave response back to the owner only
    always_comb begin
        req_o = '0;
        for (int k = 0; k < NumReq; k++) rsp_o[k] = '0;
        if (busy_o) begin
            req_o          = req_i[r_owner];
            req_o.valid    = req_i[r_owner].valid & ~w_fire;
            rsp_o[r_owner] = w_fire ? reg_rsp_t'({RegArbTimeoutRdata, 1'b1, 1'b1}) : rsp_i;
        end
    end

endmodule
